// File: rtl/sext_lane_sequencer_pkg.sv
// Shared types and lane-selection helpers for the lane sequencer.
// Lane masks are widened to MAX_LANES bits before priority encoding.
package sext_lane_sequencer_pkg;

    localparam int LANE_W    = 16;
    localparam int OUT_W     = 32;
    localparam int MAX_LANES = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int lowest_lane(
        input logic [MAX_LANES-1:0] mask
    );
        int r = 0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [MAX_LANES-1:0] lanes_above(
        input logic [MAX_LANES-1:0] mask,
        input logic [6:0]           idx
    );
        return mask & ~((64'd2 << idx) - 64'd1);
    endfunction

    function automatic int next_lane(
        input logic [MAX_LANES-1:0] mask,
        input logic [6:0]           idx
    );
        return lowest_lane(lanes_above(mask, idx));
    endfunction

    function automatic logic has_next(
        input logic [MAX_LANES-1:0] mask,
        input logic [6:0]           idx
    );
        return |lanes_above(mask, idx);
    endfunction

endpackage

// File: rtl/sext_lane_sequencer_sext.sv
// Existing 16->32 sign-extension datapath, shared by all lanes.
module SignExtension
    import sext_lane_sequencer_pkg::*;
(
    input  logic [LANE_W-1:0] In,
    output logic [OUT_W-1:0]  Out
);

    assign Out = {{(OUT_W - LANE_W){In[LANE_W-1]}}, In};

endmodule

// File: rtl/sext_lane_sequencer.sv
// Walks the enabled 16-bit lanes of a word, one sign-extended lane per cycle.
// A single SignExtension instance is time-shared across all lanes.
module sext_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = sext_lane_sequencer_pkg::LANE_W,
    parameter int OUT_W  = sext_lane_sequencer_pkg::OUT_W,
    localparam int IW    = $clog2(LANES)
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_VALID,
    output logic                    O_READY,
    input  logic [LANES*LANE_W-1:0] I_DATA,
    input  logic [LANES-1:0]        I_MASK,
    output logic                    O_VALID,
    input  logic                    I_READY,
    output logic [OUT_W-1:0]        O_DATA,
    output logic [IW-1:0]           O_LANE,
    output logic                    O_LAST,
    output logic                    O_BUSY
);

    import sext_lane_sequencer_pkg::*;

    state_t                  state_q;
    logic [LANES*LANE_W-1:0] data_q;
    logic [LANES-1:0]        mask_q;
    logic [IW-1:0]           idx_q;
    logic [LANE_W-1:0]       lane;
    logic                    last;
    logic                    run;

    assign run  = (state_q == RUN);
    assign lane = data_q[idx_q*LANE_W +: LANE_W];
    assign last = ~has_next(64'(mask_q), 7'(idx_q));

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (I_VALID) begin
                        data_q <= I_DATA;
                        mask_q <= I_MASK;
                        idx_q  <= IW'(lowest_lane(64'(I_MASK)));
                        // an all-zero mask is consumed without output
                        if (|I_MASK) state_q <= RUN;
                    end
                end
                RUN: begin
                    if (I_READY) begin
                        if (last) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q <= IW'(next_lane(64'(mask_q), 7'(idx_q)));
                        end
                    end
                end
            endcase
        end
    end

    SignExtension u_sext (
        .In  (lane),
        .Out (O_DATA)
    );

    assign O_READY = ~run;
    assign O_VALID = run;
    assign O_BUSY  = run;
    assign O_LAST  = run & last;
    assign O_LANE  = idx_q;

endmodule

// File: doc/sext_lane_sequencer.md
# sext_lane_sequencer

Sequences the existing 16→32-bit `SignExtension` datapath across the packed 16-bit lanes of a wide input word, one lane per cycle. It accepts a word plus a lane mask over a valid/ready handshake and walks the enabled lanes in ascending order. Each enabled lane's sign-extended 32-bit result is emitted on a second valid/ready handshake. It sits between the vector register read and the lane-wise vertex/immediate consumers, and shares one extender instead of replicating it per lane.

## Interface
Parameters:
- `LANES`, 4: number of 16-bit lanes per input word (power of two, ≥2).
- `LANE_W`, 16: lane width. Fixed; it matches the `SignExtension` input.
- `OUT_W`, 32: result width. Fixed; it matches the `SignExtension` output.

Ports:
- `I_CLOCK`  in  1  single clock, rising edge.
- `I_RESET`  in  1  synchronous, active-high reset.
- `I_VALID`  in  1  input word valid.
- `O_READY`  out  1  sequencer can accept a word.
- `I_DATA`  in  LANES*LANE_W  packed lanes; lane k is `I_DATA[k*16 +: 16]`.
- `I_MASK`  in  LANES  lane enable; bit k enables lane k.
- `O_VALID`  out  1  result valid.
- `I_READY`  in  1  consumer accepts the result.
- `O_DATA`  out  OUT_W  sign-extended lane value.
- `O_LANE`  out  log2(LANES)  index of the lane on `O_DATA`.
- `O_LAST`  out  1  high with the final enabled lane of a word.
- `O_BUSY`  out  1  a word is being sequenced.

## Operation
FSM with two states, IDLE and RUN.

IDLE:
- `O_READY`=1, `O_VALID`=0.
- Accept when `I_VALID`=1: register `I_DATA` and `I_MASK`, and set the index to the lowest set mask bit.
- If the accepted mask is 0, drop the word, produce no output and stay in IDLE.
- Otherwise go to RUN.

RUN:
- `O_READY`=0, `O_BUSY`=1, `O_VALID`=1.
- `O_DATA` is `SignExtension` of the registered lane at the current index.
- `O_LANE` is the current index.
- `O_LAST`=1 when no set mask bit exists above the current index.

Transfer occurs when `O_VALID`=1 and `I_READY`=1:
- If `O_LAST`=1, go to IDLE.
- Otherwise set the index to the next set mask bit above it. Cleared lanes are skipped in zero cycles.

Other rules:
- `I_VALID` is ignored while in RUN. No overlapped accept in the cycle a word's last lane transfers.
- Arithmetic: the result is bits [31:16] = lane bit 15 replicated, and bits [15:0] = the lane value. No saturation and no zero-extend mode.
- Next-lane selection is a priority encoder over `mask & ~((2 << idx) - 1)`.

Reset values: `O_READY`=1, `O_VALID`=0, `O_BUSY`=0, `O_LAST`=0, `O_LANE`=0, `O_DATA`=0. Index and state return to 0/IDLE.

## Timing
- Accept in cycle N; the first result is valid in cycle N+1 (registered operand, combinational extend).
- Throughput is one enabled lane per cycle with `I_READY` held high.
- A word with m enabled lanes occupies m RUN cycles plus stalls. `O_READY` returns high in the cycle after the last transfer.
- Backpressure: while `O_VALID`=1 and `I_READY`=0, `O_DATA`, `O_LANE` and `O_LAST` hold stable.
- Reset mid-burst: `I_RESET` sampled high in cycle N clears state, so cycle N+1 shows reset values. The pending word is discarded, with no partial `O_LAST`.
- Reset has priority over an accept or transfer in the same cycle.

## Structure
- Shared package holds:
  - `LANE_W`=16 and `OUT_W`=32 constants;
  - the state enum {IDLE, RUN};
  - a `next_lane(mask, idx)` priority-encode function.
- One sub-module: the existing `SignExtension`, instantiated once. Its `In` is driven from the registered lane mux and its `Out` drives `O_DATA`.
- Everything else (FSM, lane mux, index register) lives in `sext_lane_sequencer`.

## Test plan
- **Reset:** hold `I_RESET`=1 for 2 cycles → `O_READY`=1, `O_VALID`=0, `O_BUSY`=0, `O_DATA`=0.
- **Full mask:** mask 4'b1111, lanes 0..3 = 0x8000, 0x7FFF, 0xFFFF, 0x0001, `I_READY`=1 → four consecutive cycles.
  - `O_DATA` = 0xFFFF8000, 0x00007FFF, 0xFFFFFFFF, 0x00000001.
  - `O_LANE` = 0..3, with `O_LAST` only on the 4th cycle.
  - `O_READY`=1 the following cycle.
- **Sparse mask:** mask 4'b1010, lane1 = 0x8001, lane3 = 0x0042 → two results: lane 1 = 0xFFFF8001, then lane 3 = 0x00000042 with `O_LAST`=1.
- **Backpressure:** full mask, `I_READY`=0 for 3 cycles while lane 2 is presented → `O_DATA`/`O_LANE`/`O_LAST` unchanged for all 3 cycles, and lane 3 follows 1 cycle after `I_READY` rises.
- **Empty mask and busy inputs:**
  - Mask 0 → no `O_VALID`, and `O_READY` stays 1.
  - `I_VALID` pulsed during RUN → ignored, and the current word's outputs are unchanged.
- **Reset mid-burst:** assert `I_RESET` on lane 1 of a full-mask word → reset values next cycle. A new word with mask 4'b0100 then emits lane 2 only, with `O_LAST`=1.
